// File: rtl/elevator_pkg.sv
// Shared types and helpers for the SCAN elevator controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMoving,
        StDoor
    } state_t;

    // Upper bound on floor count; request masks are zero-padded to this width.
    localparam int MaxFloors = 32;

    // True when any request bit sits strictly above floor fl.
    function automatic logic any_above(input logic [MaxFloors-1:0] mask, input int fl);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MaxFloors; i++) begin
            if (i > fl && mask[i]) r = 1'b1;
        end
        return r;
    endfunction

    // True when any request bit sits strictly below floor fl.
    function automatic logic any_below(input logic [MaxFloors-1:0] mask, input int fl);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MaxFloors; i++) begin
            if (i < fl && mask[i]) r = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by travel and door dwell timing.
module elevator_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         hold,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    // Count down to zero and rest there; hold freezes the count entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!hold) begin
            if (load) begin
                cnt_q <= load_val;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/elevator_ctrl.sv
// N-floor elevator controller: latches requests, serves them with a SCAN policy.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS  = 8,
    parameter int unsigned MOVE_CYCLES = 2,
    parameter int unsigned DOOR_CYCLES = 4,
    localparam int unsigned FW = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] req,
    input  logic                  stop,
    output logic [FW-1:0]         floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int unsigned MaxCycles = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int unsigned TW = $clog2(MaxCycles) + 1;
    localparam logic [TW-1:0] MoveLoad = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0] DoorLoad = TW'(DOOR_CYCLES - 1);

    state_t                state_q, state_d;
    logic [FW-1:0]         floor_q, floor_d;
    logic                  dir_q, dir_d;
    logic [NUM_FLOORS-1:0] pending_q, clr;
    logic [FW-1:0]         next_floor;
    logic [MaxFloors-1:0]  pend_wide;
    logic                  above, below;
    logic                  tmr_load, tmr_expired;
    logic [TW-1:0]         tmr_val;

    assign pend_wide = MaxFloors'(pending_q);
    assign above     = any_above(pend_wide, int'(floor_q));
    assign below     = any_below(pend_wide, int'(floor_q));

    // One timer serves both travel and door dwell; the two states never overlap.
    elevator_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .hold     (stop),
        .expired  (tmr_expired)
    );

    // State, position and direction registers; pending keeps latching under stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            floor_q   <= '0;
            dir_q     <= 1'b1;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            pending_q <= (pending_q | req) & ~clr;
        end
    end

    // SCAN next-state logic, timer control and request clearing.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        clr        = '0;
        next_floor = dir_q ? floor_q + 1'b1 : floor_q - 1'b1;

        if (!stop) begin
            unique case (state_q)
                StIdle: begin
                    if (pending_q[floor_q]) begin
                        state_d      = StDoor;
                        clr[floor_q] = 1'b1;
                        tmr_load     = 1'b1;
                        tmr_val      = DoorLoad;
                    end else if (above && (dir_q || !below)) begin
                        dir_d    = 1'b1;
                        state_d  = StMoving;
                        tmr_load = 1'b1;
                        tmr_val  = MoveLoad;
                    end else if (below) begin
                        dir_d    = 1'b0;
                        state_d  = StMoving;
                        tmr_load = 1'b1;
                        tmr_val  = MoveLoad;
                    end
                end
                StMoving: begin
                    if (tmr_expired) begin
                        floor_d = next_floor;
                        if (pending_q[next_floor]) begin
                            state_d         = StDoor;
                            clr[next_floor] = 1'b1;
                            tmr_load        = 1'b1;
                            tmr_val         = DoorLoad;
                        end else if (dir_q ? any_above(pend_wide, int'(next_floor))
                                           : any_below(pend_wide, int'(next_floor))) begin
                            tmr_load = 1'b1;
                            tmr_val  = MoveLoad;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StDoor: begin
                    // A fresh call for this floor keeps the door open longer.
                    if (req[floor_q]) begin
                        tmr_load = 1'b1;
                        tmr_val  = DoorLoad;
                    end else if (tmr_expired) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Calls for the floor whose door is open are absorbed, even while held.
        if (state_q == StDoor && req[floor_q]) clr[floor_q] = 1'b1;
    end

    assign floor     = floor_q;
    assign dir_up    = dir_q;
    assign moving    = (state_q == StMoving);
    assign door_open = (state_q == StDoor);
    assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl: cycle-exact vector table plus corner sequences.
module tb_elevator_ctrl;

    localparam int unsigned NF = 4;

    logic          clk;
    logic          rst;
    logic [NF-1:0] req;
    logic          stop;
    logic [1:0]    floor;
    logic          dir_up;
    logic          moving;
    logic          door_open;
    logic [NF-1:0] pending;

    int total;
    int bad;

    typedef struct {
        logic       rst;
        logic       stop;
        logic [3:0] req;
        logic [1:0] floor;
        logic       dir_up;
        logic       moving;
        logic       door_open;
        logic [3:0] pending;
    } vec_t;

    vec_t tab[$];

    elevator_ctrl #(
        .NUM_FLOORS  (NF),
        .MOVE_CYCLES (2),
        .DOOR_CYCLES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .stop      (stop),
        .floor     (floor),
        .dir_up    (dir_up),
        .moving    (moving),
        .door_open (door_open),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input logic [3:0] q,
                                input logic [1:0] f, input logic d, input logic m,
                                input logic o, input logic [3:0] p);
        vec_t v;
        v.rst = r; v.stop = s; v.req = q;
        v.floor = f; v.dir_up = d; v.moving = m; v.door_open = o; v.pending = p;
        return v;
    endfunction

    // Drive inputs, take one edge, sample 1 time unit later.
    task automatic step(input logic [3:0] r, input logic s, input logic rs);
        req = r; stop = s; rst = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_door(input logic [1:0] f, input string name);
        for (int i = 0; i < 40; i++) begin
            if (door_open && floor == f) break;
            step(4'b0000, 1'b0, 1'b0);
        end
        check(name, {15'd0, door_open && floor == f}, 16'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = '0;
        stop  = 1'b0;

        // rst stop req | floor dir mov door pend
        tab.push_back(mk(1, 0, 4'b0000, 0, 1, 0, 0, 4'b0000));
        // call at the current floor
        tab.push_back(mk(0, 0, 4'b0001, 0, 1, 0, 0, 4'b0001));
        tab.push_back(mk(0, 0, 4'b0000, 0, 1, 0, 1, 4'b0000));
        tab.push_back(mk(0, 0, 4'b0000, 0, 1, 0, 1, 4'b0000));
        tab.push_back(mk(0, 0, 4'b0000, 0, 1, 0, 1, 4'b0000));
        tab.push_back(mk(0, 0, 4'b0000, 0, 1, 0, 0, 4'b0000));
        // single trip 0 -> 2
        tab.push_back(mk(0, 0, 4'b0100, 0, 1, 0, 0, 4'b0100));
        tab.push_back(mk(0, 0, 4'b0000, 0, 1, 1, 0, 4'b0100));
        tab.push_back(mk(0, 0, 4'b0000, 0, 1, 1, 0, 4'b0100));
        tab.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0, 4'b0100));
        tab.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0, 4'b0100));
        tab.push_back(mk(0, 0, 4'b0000, 2, 1, 0, 1, 4'b0000));
        tab.push_back(mk(0, 0, 4'b0000, 2, 1, 0, 1, 4'b0000));
        tab.push_back(mk(0, 0, 4'b0000, 2, 1, 0, 1, 4'b0000));
        tab.push_back(mk(0, 0, 4'b0000, 2, 1, 0, 0, 4'b0000));
        // two stops on the way up: 1 then 3
        tab.push_back(mk(1, 0, 4'b0000, 0, 1, 0, 0, 4'b0000));
        tab.push_back(mk(0, 0, 4'b1010, 0, 1, 0, 0, 4'b1010));
        tab.push_back(mk(0, 0, 4'b0000, 0, 1, 1, 0, 4'b1010));
        tab.push_back(mk(0, 0, 4'b0000, 0, 1, 1, 0, 4'b1010));
        tab.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 1, 4'b1000));
        tab.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 1, 4'b1000));
        tab.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 1, 4'b1000));
        tab.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0, 4'b1000));
        tab.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0, 4'b1000));
        tab.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0, 4'b1000));
        tab.push_back(mk(0, 0, 4'b0000, 2, 1, 1, 0, 4'b1000));
        tab.push_back(mk(0, 0, 4'b0000, 2, 1, 1, 0, 4'b1000));
        tab.push_back(mk(0, 0, 4'b0000, 3, 1, 0, 1, 4'b0000));
        tab.push_back(mk(0, 0, 4'b0000, 3, 1, 0, 1, 4'b0000));
        tab.push_back(mk(0, 0, 4'b0000, 3, 1, 0, 1, 4'b0000));
        tab.push_back(mk(0, 0, 4'b0000, 3, 1, 0, 0, 4'b0000));
        // door extension by a call absorbed at the open floor
        tab.push_back(mk(0, 0, 4'b1000, 3, 1, 0, 0, 4'b1000));
        tab.push_back(mk(0, 0, 4'b0000, 3, 1, 0, 1, 4'b0000));
        tab.push_back(mk(0, 0, 4'b0000, 3, 1, 0, 1, 4'b0000));
        tab.push_back(mk(0, 0, 4'b1000, 3, 1, 0, 1, 4'b0000));
        tab.push_back(mk(0, 0, 4'b0000, 3, 1, 0, 1, 4'b0000));
        tab.push_back(mk(0, 0, 4'b0000, 3, 1, 0, 1, 4'b0000));
        tab.push_back(mk(0, 0, 4'b0000, 3, 1, 0, 0, 4'b0000));

        for (int i = 0; i < tab.size(); i++) begin
            step(tab[i].req, tab[i].stop, tab[i].rst);
            check($sformatf("vec%0d", i),
                  {7'd0, floor, dir_up, moving, door_open, pending},
                  {7'd0, tab[i].floor, tab[i].dir_up, tab[i].moving, tab[i].door_open,
                   tab[i].pending});
        end

        // stop held 5 cycles mid-move delays arrival exactly 5 cycles
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check("stop_start_moving", {15'd0, moving}, 16'd1);
        for (int i = 0; i < 5; i++) begin
            step((i == 0) ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
            check($sformatf("stop_hold%0d", i), {13'd0, floor, moving}, {13'd0, 2'd0, 1'b1});
        end
        check("stop_req_latched", {12'd0, pending}, {12'd0, 4'b0101});
        step(4'b0000, 1'b0, 1'b0);
        check("stop_release_f0", {14'd0, floor}, 16'd0);
        step(4'b0000, 1'b0, 1'b0);
        check("stop_release_f1", {14'd0, floor}, 16'd1);

        // reversal: serve 3 first, then travel down to 0, then back up to 3
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b1001, 1'b0, 1'b0);
        check("rev_pending", {12'd0, pending}, {12'd0, 4'b1101});
        wait_door(2'd2, "rev_reach2");
        check("rev_pend_at2", {12'd0, pending}, {12'd0, 4'b1001});
        wait_door(2'd3, "rev_reach3");
        check("rev_dir_at3", {15'd0, dir_up}, 16'd1);
        check("rev_pend_at3", {12'd0, pending}, {12'd0, 4'b0001});
        for (int i = 0; i < 20; i++) begin
            if (moving) break;
            step(4'b0000, 1'b0, 1'b0);
        end
        check("rev_down_start", {13'd0, floor, moving, dir_up}, {13'd0, 2'd3, 1'b1, 1'b0});
        // call for the floor just departed stays pending
        step(4'b1000, 1'b0, 1'b0);
        check("rev_departed_req", {12'd0, pending}, {12'd0, 4'b1001});
        wait_door(2'd0, "rev_reach0");
        check("rev_dir_at0", {15'd0, dir_up}, 16'd0);
        check("rev_pend_at0", {12'd0, pending}, {12'd0, 4'b1000});
        wait_door(2'd3, "rev_back3");
        check("rev_dir_back", {15'd0, dir_up}, 16'd1);
        check("rev_pend_end", {12'd0, pending}, 16'd0);

        // reset with the door open and a call still pending
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        wait_door(2'd2, "rst_reach2");
        check("rst_pend_before", {12'd0, pending}, {12'd0, 4'b1000});
        step(4'b0000, 1'b0, 1'b1);
        check("rst_outputs", {7'd0, floor, dir_up, moving, door_open, pending},
              {7'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000});
        step(4'b0000, 1'b0, 1'b0);
        check("rst_stays_idle", {7'd0, floor, dir_up, moving, door_open, pending},
              {7'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
